apb_arbiter_master: RTL and testbench
=====================================

APB_ARBITER_MASTER -- requirements
Module: apb_arbiter_master

Interface
REQ-001 Parameters SHALL be:
- BASE_ADDR, 32'h1000_0000, base of peripheral region.
- TIMEOUT, 16, max ACCESS cycles before forced completion.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high. Ports are as follows.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mN_transfer (N=0,1)  in  1  request; held high by master until mN_ready
- mN_busWe  in  1  write=1 / read=0
- mN_busAddr  in  32  byte address
- mN_busWData  in  32  write data
- mN_strb  in  3  access size code, passed through
- mN_busRData  out  32  read data, valid when mN_ready=1
- mN_ready  out  1  one-cycle completion strobe
- PADDR  out  32  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSTRB  out  3  captured strb
- PENABLE  out  1  APB access phase
- PSEL  out  4  one-hot slave select
- PRDATA0..PRDATA3  in  32 each  slave read data
- PREADY  in  4  per-slave ready
- bus_err  out  1  one-cycle strobe on unmapped or timed-out access

Function
REQ-003 The FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-004 In IDLE with exactly one mN_transfer=1, the block SHALL grant N.
REQ-005 In IDLE with both requests high, the block SHALL grant the master not granted last (round-robin).
REQ-006 On grant, the block SHALL capture addr, wdata, we and strb into registers, record the grant index, and go to SETUP on the next edge.
REQ-007 PADDR, PWDATA, PWRITE and PSTRB SHALL be driven from the captured registers only and SHALL stay stable from SETUP through the completing ACCESS cycle.
REQ-008 Address decode SHALL be: addr[31:12] = BASE_ADDR[31:12]+k, k=0..3, selects PSEL[k]; any other address is unmapped.
REQ-009 In SETUP, the block SHALL assert PSEL[k]=1 and PENABLE=0 for exactly one cycle, then go to ACCESS.
REQ-010 In ACCESS, PENABLE SHALL be 1 and PSEL[k] SHALL stay 1 until completion.
REQ-011 Completion SHALL occur in the ACCESS cycle where PREADY[k]=1: mN_ready=1 for the granted N (combinational), mN_busRData=PRDATAk, and the FSM returns to IDLE.
REQ-012 The non-granted master SHALL see ready=0 and busRData=0.
REQ-013 For an unmapped address, PSEL SHALL be 4'b0000 in SETUP and ACCESS, and the first ACCESS cycle SHALL complete with busRData=0 and bus_err=1.
REQ-014 A counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without PREADY[k].
- When the count reaches TIMEOUT, that cycle SHALL complete with busRData=32'hDEAD_BEEF and bus_err=1.
- Completion by PREADY in that same cycle SHALL win (normal data, no error).
REQ-015 Minimum latency SHALL be 3 cycles: request seen in IDLE at cycle 0, SETUP at 1, ready at 2 with a zero-wait slave.
REQ-016 A master's transfer dropping before completion SHALL NOT abort an access that has already been granted.
REQ-017 PREADY and PRDATA of unselected slaves SHALL be ignored.
REQ-018 Back-to-back requests SHALL be accepted: IDLE may grant in the cycle immediately after completion.

Reset
REQ-019 Reset SHALL be asynchronous and active-high.
- State becomes IDLE.
- PSEL, PENABLE, PWRITE, bus_err and mN_ready become 0.
- PADDR, PWDATA, PSTRB and the timeout counter become 0.
- last_grant becomes 1, so m0 wins the first tie.
REQ-020 Reset asserted mid-SETUP or mid-ACCESS SHALL drop PSEL and PENABLE immediately and SHALL produce no ready pulse.

Verification
REQ-021 m0 read of 0x1000_0004 with PREADY[0]=1 and PRDATA0=0x1234_5678 -> PSEL=0001 at cycle 1; PENABLE at 2; m0_ready=1 with data 0x1234_5678 at cycle 2.
REQ-022 m0 and m1 request simultaneously after reset -> m0 served first, m1 second; with both still requesting, the grant sequence alternates m0,m1,m0,m1.
REQ-023 m1 write 0xCAFE_0001 to 0x1000_2010 with PREADY[2] low for 3 ACCESS cycles -> PWDATA, PADDR and PSEL=0100 stable throughout; m1_ready in the 4th ACCESS cycle.
REQ-024 m0 read of 0x2000_0000 -> PSEL=0000; m0_ready=1 with data 0 and bus_err=1 at cycle 2.
REQ-025 Read of 0x1000_3000 with PREADY[3] stuck at 0 -> completion after TIMEOUT=16 ACCESS cycles with data 0xDEAD_BEEF and bus_err=1.
REQ-026 Reset asserted in the second ACCESS cycle -> PSEL and PENABLE low before the next edge; no ready pulse; m0 wins the next tie.

Source files
------------

// File: rtl/apb_arbiter_master_if.sv
// Bundle of the two master request ports and the APB side of the arbiter.
interface apb_arbiter_master_if;
  logic        m0_transfer;
  logic        m0_busWe;
  logic [31:0] m0_busAddr;
  logic [31:0] m0_busWData;
  logic [2:0]  m0_strb;
  logic [31:0] m0_busRData;
  logic        m0_ready;

  logic        m1_transfer;
  logic        m1_busWe;
  logic [31:0] m1_busAddr;
  logic [31:0] m1_busWData;
  logic [2:0]  m1_strb;
  logic [31:0] m1_busRData;
  logic        m1_ready;

  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic [2:0]  PSTRB;
  logic        PENABLE;
  logic [3:0]  PSEL;
  logic [31:0] PRDATA0;
  logic [31:0] PRDATA1;
  logic [31:0] PRDATA2;
  logic [31:0] PRDATA3;
  logic [3:0]  PREADY;
  logic        bus_err;

  // Arbiter view: takes master requests, drives the APB bus
  modport master (
    input  m0_transfer, m0_busWe, m0_busAddr, m0_busWData, m0_strb,
    output m0_busRData, m0_ready,
    input  m1_transfer, m1_busWe, m1_busAddr, m1_busWData, m1_strb,
    output m1_busRData, m1_ready,
    output PADDR, PWDATA, PWRITE, PSTRB, PENABLE, PSEL, bus_err,
    input  PRDATA0, PRDATA1, PRDATA2, PRDATA3, PREADY
  );

  // Environment view: the two bus masters and the four APB slaves
  modport slave (
    output m0_transfer, m0_busWe, m0_busAddr, m0_busWData, m0_strb,
    input  m0_busRData, m0_ready,
    output m1_transfer, m1_busWe, m1_busAddr, m1_busWData, m1_strb,
    input  m1_busRData, m1_ready,
    input  PADDR, PWDATA, PWRITE, PSTRB, PENABLE, PSEL, bus_err,
    output PRDATA0, PRDATA1, PRDATA2, PRDATA3, PREADY
  );
endinterface

// File: rtl/apb_arbiter_master.sv
// Two-master round-robin arbiter driving a four-slave APB bus.
// Requests are captured on grant; the APB fields come only from those registers.
// Unmapped addresses and stalled slaves complete with bus_err.
module apb_arbiter_master #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input logic                  clk,
  input logic                  reset,
  apb_arbiter_master_if.master bus
);

  // Counter only has to reach TIMEOUT-1: that ACCESS cycle is the forced completion.
  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            gnt_q, gnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [2:0]      strb_q, strb_d;
  logic            mapped_q, mapped_d;
  logic [1:0]      slv_q, slv_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        grant_idx;
  logic [31:0] req_addr;
  logic [19:0] page;
  logic        sel_ready;
  logic [31:0] sel_rdata;
  logic        timeout_hit;
  logic        done;
  logic [31:0] done_rdata;
  logic        done_err;

  // Pick the winning master (round-robin on a tie) and decode its address page
  always_comb begin
    if (bus.m0_transfer && bus.m1_transfer) begin
      grant_idx = ~last_grant_q;
    end else begin
      grant_idx = bus.m1_transfer;
    end
    req_addr = grant_idx ? bus.m1_busAddr : bus.m0_busAddr;
    page     = req_addr[31:12] - BASE_ADDR[31:12];
  end

  // Completion condition and returned data for the current ACCESS cycle
  always_comb begin
    sel_ready = bus.PREADY[slv_q];
    unique case (slv_q)
      2'd0:    sel_rdata = bus.PRDATA0;
      2'd1:    sel_rdata = bus.PRDATA1;
      2'd2:    sel_rdata = bus.PRDATA2;
      default: sel_rdata = bus.PRDATA3;
    endcase
    timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));
    done        = !mapped_q || sel_ready || timeout_hit;
    // PREADY takes precedence over a timeout landing in the same cycle
    if (!mapped_q) begin
      done_rdata = '0;
      done_err   = 1'b1;
    end else if (sel_ready) begin
      done_rdata = sel_rdata;
      done_err   = 1'b0;
    end else begin
      done_rdata = 32'hDEAD_BEEF;
      done_err   = 1'b1;
    end
  end

  // Next-state: grant and capture in idle, one setup cycle, access until done
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    strb_d       = strb_q;
    mapped_d     = mapped_q;
    slv_d        = slv_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.m0_transfer || bus.m1_transfer) begin
          state_d      = StSetup;
          gnt_d        = grant_idx;
          last_grant_d = grant_idx;
          addr_d       = req_addr;
          wdata_d      = grant_idx ? bus.m1_busWData : bus.m0_busWData;
          we_d         = grant_idx ? bus.m1_busWe : bus.m0_busWe;
          strb_d       = grant_idx ? bus.m1_strb : bus.m0_strb;
          mapped_d     = (page < 20'd4);
          slv_d        = page[1:0];
        end
      end
      StSetup: begin
        state_d = StAccess;
        cnt_d   = '0;
      end
      StAccess: begin
        if (done) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and capture registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      strb_q       <= '0;
      mapped_q     <= 1'b0;
      slv_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      strb_q       <= strb_d;
      mapped_q     <= mapped_d;
      slv_q        <= slv_d;
      cnt_q        <= cnt_d;
    end
  end

  // Bus outputs; ready/data/err are combinational in the completing ACCESS cycle
  always_comb begin
    bus.PADDR       = addr_q;
    bus.PWDATA      = wdata_q;
    bus.PWRITE      = we_q;
    bus.PSTRB       = strb_q;
    bus.PSEL        = '0;
    bus.PENABLE     = 1'b0;
    bus.bus_err     = 1'b0;
    bus.m0_ready    = 1'b0;
    bus.m1_ready    = 1'b0;
    bus.m0_busRData = '0;
    bus.m1_busRData = '0;
    if (state_q != StIdle && mapped_q) begin
      bus.PSEL = 4'b0001 << slv_q;
    end
    if (state_q == StAccess) begin
      bus.PENABLE = 1'b1;
      if (done) begin
        bus.bus_err = done_err;
        if (gnt_q) begin
          bus.m1_ready    = 1'b1;
          bus.m1_busRData = done_rdata;
        end else begin
          bus.m0_ready    = 1'b1;
          bus.m0_busRData = done_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_arbiter_master.sv
// Self-checking bench: directed vector table, hand sequences for tie and
// mid-access reset, then random traffic against a cycle-level reference model.
module tb_apb_arbiter_master;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          TMO  = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  apb_arbiter_master_if bus ();

  apb_arbiter_master #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          mst;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  strb;
    int          waits;
    logic [31:0] prdata;
    bit          drop;
    logic [3:0]  exp_psel;
    int          exp_acc;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_master(input int m, input bit tr, input bit we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [2:0] s);
    if (m == 0) begin
      bus.m0_transfer = tr; bus.m0_busWe = we; bus.m0_busAddr = a;
      bus.m0_busWData = wd; bus.m0_strb = s;
    end else begin
      bus.m1_transfer = tr; bus.m1_busWe = we; bus.m1_busAddr = a;
      bus.m1_busWData = wd; bus.m1_strb = s;
    end
  endtask

  task automatic set_prdata(input int i, input logic [31:0] d);
    case (i)
      0:       bus.PRDATA0 = d;
      1:       bus.PRDATA1 = d;
      2:       bus.PRDATA2 = d;
      default: bus.PRDATA3 = d;
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_master(0, 0, 0, '0, '0, '0);
    set_master(1, 0, 0, '0, '0, '0);
    bus.PREADY = '0;
    for (int i = 0; i < 4; i++) set_prdata(i, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst PSEL", bus.PSEL, 4'b0000);
    chk("rst PENABLE", bus.PENABLE, 0);
    chk("rst PWRITE", bus.PWRITE, 0);
    chk("rst bus_err", bus.bus_err, 0);
    chk("rst m0_ready", bus.m0_ready, 0);
    chk("rst m1_ready", bus.m1_ready, 0);
    chk("rst PADDR", bus.PADDR, 32'h0);
    chk("rst PWDATA", bus.PWDATA, 32'h0);
    chk("rst PSTRB", bus.PSTRB, 3'b000);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic vec_t mk(bit mst, bit we, logic [31:0] a, logic [31:0] wd, logic [2:0] s,
                              int waits, logic [31:0] pd, bit drop, logic [3:0] psel,
                              int acc, logic [31:0] rd, bit err);
    vec_t v;
    v.mst = mst; v.we = we; v.addr = a; v.wdata = wd; v.strb = s; v.waits = waits;
    v.prdata = pd; v.drop = drop; v.exp_psel = psel; v.exp_acc = acc;
    v.exp_rdata = rd; v.exp_err = err;
    return v;
  endfunction

  // One isolated transfer; unselected slaves keep PREADY high with junk data
  task automatic run_vec(input vec_t v, input int idx);
    int k = -1;
    int om = v.mst ? 0 : 1;
    for (int i = 0; i < 4; i++) if (v.exp_psel[i]) k = i;
    @(posedge clk); #1;
    set_master(om, 0, 0, '0, '0, '0);
    set_master(int'(v.mst), 1, v.we, v.addr, v.wdata, v.strb);
    bus.PREADY = 4'hF;
    for (int i = 0; i < 4; i++) set_prdata(i, (i == k) ? v.prdata : $urandom);
    @(negedge clk);
    chk($sformatf("v%0d idle PSEL", idx), bus.PSEL, 4'b0000);
    chk($sformatf("v%0d idle ready", idx), {bus.m1_ready, bus.m0_ready}, 2'b00);
    @(posedge clk); #1;
    if (v.drop) set_master(int'(v.mst), 0, v.we, v.addr, v.wdata, v.strb);
    @(negedge clk);
    chk($sformatf("v%0d setup PSEL", idx), bus.PSEL, v.exp_psel);
    chk($sformatf("v%0d setup PENABLE", idx), bus.PENABLE, 0);
    chk($sformatf("v%0d setup PADDR", idx), bus.PADDR, v.addr);
    chk($sformatf("v%0d setup PWDATA", idx), bus.PWDATA, v.wdata);
    chk($sformatf("v%0d setup PWRITE", idx), bus.PWRITE, v.we);
    chk($sformatf("v%0d setup PSTRB", idx), bus.PSTRB, v.strb);
    chk($sformatf("v%0d setup ready", idx), {bus.m1_ready, bus.m0_ready}, 2'b00);
    for (int a = 0; a < v.exp_acc; a++) begin
      bit last = (a == v.exp_acc - 1);
      @(posedge clk); #1;
      bus.PREADY = 4'hF;
      if (k >= 0) bus.PREADY[k] = (a >= v.waits);
      @(negedge clk);
      chk($sformatf("v%0d acc%0d PENABLE", idx, a), bus.PENABLE, 1);
      chk($sformatf("v%0d acc%0d PSEL", idx, a), bus.PSEL, v.exp_psel);
      chk($sformatf("v%0d acc%0d PADDR", idx, a), bus.PADDR, v.addr);
      chk($sformatf("v%0d acc%0d PWDATA", idx, a), bus.PWDATA, v.wdata);
      chk($sformatf("v%0d acc%0d bus_err", idx, a), bus.bus_err, last ? v.exp_err : 1'b0);
      if (v.mst) begin
        chk($sformatf("v%0d acc%0d m1_ready", idx, a), bus.m1_ready, last);
        chk($sformatf("v%0d acc%0d m0 idle", idx, a), {bus.m0_ready, bus.m0_busRData}, 33'h0);
        if (last) chk($sformatf("v%0d m1 rdata", idx), bus.m1_busRData, v.exp_rdata);
      end else begin
        chk($sformatf("v%0d acc%0d m0_ready", idx, a), bus.m0_ready, last);
        chk($sformatf("v%0d acc%0d m1 idle", idx, a), {bus.m1_ready, bus.m1_busRData}, 33'h0);
        if (last) chk($sformatf("v%0d m0 rdata", idx), bus.m0_busRData, v.exp_rdata);
      end
    end
    @(posedge clk); #1;
    set_master(int'(v.mst), 0, 0, '0, '0, '0);
    @(negedge clk);
    chk($sformatf("v%0d post PENABLE", idx), bus.PENABLE, 0);
    chk($sformatf("v%0d post PSEL", idx), bus.PSEL, 4'b0000);
  endtask

  function automatic logic [31:0] rand_addr();
    int c = $urandom_range(0, 5);
    logic [31:0] a;
    if (c < 4) a = BASE + 32'(c * 4096) + 32'($urandom_range(0, 1023) * 4);
    else if (c == 4) a = $urandom;
    else begin
      case ($urandom_range(0, 2))
        0:       a = BASE - 32'd4;
        1:       a = BASE + 32'h4000;
        default: a = BASE + 32'h3FFC;
      endcase
    end
    return a;
  endfunction

  // Slave index an address falls in, or -1 when it maps to nothing
  function automatic int slave_of(logic [31:0] a);
    if (a >= BASE && a < BASE + 32'h4000) return int'((a - BASE) / 32'd4096);
    return -1;
  endfunction

  // Random traffic; the model tracks a transaction by its age in cycles since grant
  task automatic run_random(input int ncyc);
    bit          rq[2];
    bit          wt[2];
    logic [31:0] ra[2];
    logic [31:0] rw[2];
    bit          rwe[2];
    logic [2:0]  rs[2];
    logic [31:0] pd[4];
    logic [3:0]  pr;
    bit          act = 0;
    int          age = 0;
    int          gnt = 0;
    int          last = 1;
    int          stall = 0;
    logic [31:0] ca = '0;
    logic [31:0] cw = '0;
    bit          cwe = 0;
    logic [2:0]  cs = '0;
    for (int m = 0; m < 2; m++) begin rq[m] = 0; wt[m] = 0; end
    for (int c = 0; c < ncyc; c++) begin
      bit          done;
      bit          err;
      logic [31:0] rd;
      logic [3:0]  psel;
      int          k;
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        if (!wt[m] && $urandom_range(0, 3) == 0) begin
          wt[m] = 1; rq[m] = 1; ra[m] = rand_addr(); rw[m] = $urandom;
          rwe[m] = 1'($urandom_range(0, 1)); rs[m] = 3'($urandom_range(0, 7));
        end else if (rq[m] && act && gnt == m && $urandom_range(0, 15) == 0) begin
          rq[m] = 0;
        end
        set_master(m, rq[m], rwe[m], ra[m], rw[m], rs[m]);
      end
      if (stall > 0) begin
        pr = '0;
        stall--;
      end else begin
        if ($urandom_range(0, 149) == 0) stall = $urandom_range(10, 25);
        for (int i = 0; i < 4; i++) pr[i] = ($urandom_range(0, 2) == 0);
      end
      bus.PREADY = pr;
      for (int i = 0; i < 4; i++) begin pd[i] = $urandom; set_prdata(i, pd[i]); end
      @(negedge clk);
      done = 0; err = 0; rd = '0; psel = '0;
      k = slave_of(ca);
      if (act && k >= 0) psel = 4'(1 << k);
      if (act && age >= 2) begin
        if (k < 0) begin done = 1; err = 1; rd = '0; end
        else if (pr[k]) begin done = 1; rd = pd[k]; end
        else if (age - 2 == TMO - 1) begin done = 1; err = 1; rd = 32'hDEAD_BEEF; end
      end
      chk("rnd PSEL", bus.PSEL, psel);
      chk("rnd PENABLE", bus.PENABLE, act && age >= 2);
      chk("rnd bus_err", bus.bus_err, done && err);
      chk("rnd m0_ready", bus.m0_ready, done && gnt == 0);
      chk("rnd m1_ready", bus.m1_ready, done && gnt == 1);
      if (done && gnt == 0) chk("rnd m0 rdata", bus.m0_busRData, rd);
      if (done && gnt == 1) chk("rnd m1 rdata", bus.m1_busRData, rd);
      if (act && gnt == 1) chk("rnd m0 rdata idle", bus.m0_busRData, 32'h0);
      if (act && gnt == 0) chk("rnd m1 rdata idle", bus.m1_busRData, 32'h0);
      if (act) begin
        chk("rnd PADDR", bus.PADDR, ca);
        chk("rnd PWDATA", bus.PWDATA, cw);
        chk("rnd PWRITE", bus.PWRITE, cwe);
        chk("rnd PSTRB", bus.PSTRB, cs);
      end
      if (act) begin
        if (done) begin act = 0; wt[gnt] = 0; rq[gnt] = 0; end
        else age++;
      end else if (rq[0] || rq[1]) begin
        gnt = (rq[0] && rq[1]) ? 1 - last : (rq[1] ? 1 : 0);
        last = gnt;
        ca = ra[gnt]; cw = rw[gnt]; cwe = rwe[gnt]; cs = rs[gnt];
        act = 1; age = 1;
      end
    end
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = mk(0, 0, 32'h1000_0004, 32'h0, 3'd2, 0, 32'h1234_5678, 0, 4'b0001, 1,
               32'h1234_5678, 0);
    vt[1] = mk(1, 1, 32'h1000_2010, 32'hCAFE_0001, 3'd7, 3, 32'h5555_AAAA, 0, 4'b0100, 4,
               32'h5555_AAAA, 0);
    vt[2] = mk(0, 0, 32'h2000_0000, 32'h0, 3'd0, 0, 32'h9999_9999, 0, 4'b0000, 1, 32'h0, 1);
    vt[3] = mk(0, 0, 32'h1000_3000, 32'h0, 3'd1, 100, 32'h7777_7777, 0, 4'b1000, 16,
               32'hDEAD_BEEF, 1);
    vt[4] = mk(1, 0, 32'h1000_1FFC, 32'h0, 3'd3, 1, 32'hA5A5_0001, 0, 4'b0010, 2,
               32'hA5A5_0001, 0);
    vt[5] = mk(0, 0, 32'h1000_3FFC, 32'h0, 3'd2, 15, 32'h0BAD_F00D, 0, 4'b1000, 16,
               32'h0BAD_F00D, 0);
    vt[6] = mk(1, 0, 32'h1000_4000, 32'h0, 3'd0, 0, 32'h1, 0, 4'b0000, 1, 32'h0, 1);
    vt[7] = mk(0, 1, 32'h0FFF_FFFC, 32'h1357_9BDF, 3'd5, 0, 32'h2, 0, 4'b0000, 1, 32'h0, 1);
    vt[8] = mk(1, 0, 32'h1000_0000, 32'h0, 3'd4, 2, 32'h1111_2222, 1, 4'b0001, 3,
               32'h1111_2222, 0);
    vt[9] = mk(0, 0, 32'h1000_2000, 32'h0, 3'd6, 14, 32'h3333_4444, 0, 4'b0100, 15,
               32'h3333_4444, 0);

    do_reset();

    // Simultaneous requests held high: m0 first, then strict alternation
    @(posedge clk); #1;
    set_master(0, 1, 0, BASE + 32'h4, '0, '0);
    set_master(1, 1, 0, BASE + 32'h1004, '0, '0);
    bus.PREADY = 4'hF;
    set_prdata(0, 32'hA0A0_0000);
    set_prdata(1, 32'hB1B1_1111);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("tie c%0d m0_ready", c), bus.m0_ready, (c % 6) == 2);
      chk($sformatf("tie c%0d m1_ready", c), bus.m1_ready, (c % 6) == 5);
      if ((c % 6) == 2) chk("tie m0 rdata", bus.m0_busRData, 32'hA0A0_0000);
      if ((c % 6) == 5) chk("tie m1 rdata", bus.m1_busRData, 32'hB1B1_1111);
    end
    @(posedge clk); #1;
    set_master(0, 0, 0, '0, '0, '0);
    set_master(1, 0, 0, '0, '0, '0);
    @(negedge clk);
    chk("tie end PENABLE", bus.PENABLE, 0);

    // Reset in the second ACCESS cycle of an m0 access, then a tie
    @(posedge clk); #1;
    set_master(0, 1, 0, BASE, '0, '0);
    bus.PREADY = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid pre PENABLE", bus.PENABLE, 1);
    reset = 1'b1;
    set_master(0, 0, 0, '0, '0, '0);
    #1;
    chk("mid rst PSEL", bus.PSEL, 4'b0000);
    chk("mid rst PENABLE", bus.PENABLE, 0);
    chk("mid rst ready", {bus.m1_ready, bus.m0_ready}, 2'b00);
    chk("mid rst bus_err", bus.bus_err, 0);
    @(posedge clk); #1;
    chk("mid rst ready2", {bus.m1_ready, bus.m0_ready}, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    set_master(0, 1, 0, BASE + 32'h8, '0, '0);
    set_master(1, 1, 0, BASE + 32'h1008, '0, '0);
    bus.PREADY = 4'hF;
    repeat (3) @(negedge clk);
    chk("post rst tie m0_ready", bus.m0_ready, 1);
    chk("post rst tie m1_ready", bus.m1_ready, 0);
    @(posedge clk); #1;
    set_master(0, 0, 0, '0, '0, '0);
    set_master(1, 0, 0, '0, '0, '0);
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vt[i], i);

    do_reset();
    run_random(4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
